// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: h/v counters plus a registered decode that
// produces sync, data-enable, active coordinates and a frame-start pulse.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] hactive,
  output logic [15:0] vactive,
  output logic        timing_hs,
  output logic        timing_vs,
  output logic        timing_de,
  output logic [11:0] timing_x,
  output logic [11:0] timing_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_frame_start;

  logic        w_hs;
  logic        w_vs;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_de;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic        w_frame_start;

  assign hactive = 16'(H_ACTIVE);
  assign vactive = 16'(V_ACTIVE);

  // Decode of the current counter position; registered below for one-cycle latency.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_hs          = ~HS_POL;
    w_vs          = ~VS_POL;
    w_x           = '0;
    w_y           = '0;
    w_h_act       = (r_h_cnt >= H_ACT_START) && (r_h_cnt < H_ACT_END);
    w_v_act       = (r_v_cnt >= V_ACT_START) && (r_v_cnt < V_ACT_END);
    w_de          = w_h_act && w_v_act;
    w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    if (r_h_cnt < H_SYNC_END) w_hs = HS_POL;
    if (r_v_cnt < V_SYNC_END) w_vs = VS_POL;
    if (w_de) begin
      w_x = r_h_cnt - H_ACT_START;
      w_y = r_v_cnt - V_ACT_START;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the counters together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else if (en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 12'd1;
      end
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_de          <= w_de;
      r_x           <= w_x;
      r_y           <= w_y;
      r_frame_start <= w_frame_start;
    end
  end

  assign timing_hs   = r_hs;
  assign timing_vs   = r_vs;
  assign timing_de   = r_de;
  assign timing_x    = r_x;
  assign timing_y    = r_y;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: small-raster DUTs with both sync polarities plus a 1080p instance
// for constants and the start of the first line.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  logic [15:0] a_hact, a_vact, b_hact, b_vact, c_hact, c_vact;
  logic a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs, c_hs, c_vs, c_de, c_fs;
  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .hactive(a_hact), .vactive(a_vact),
    .timing_hs(a_hs), .timing_vs(a_vs), .timing_de(a_de),
    .timing_x(a_x), .timing_y(a_y), .frame_start(a_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .hactive(b_hact), .vactive(b_vact),
    .timing_hs(b_hs), .timing_vs(b_vs), .timing_de(b_de),
    .timing_x(b_x), .timing_y(b_y), .frame_start(b_fs)
  );

  video_timing_gen dut_c (
    .clk(clk), .rst(rst), .en(en), .hactive(c_hact), .vactive(c_vact),
    .timing_hs(c_hs), .timing_vs(c_vs), .timing_de(c_de),
    .timing_x(c_x), .timing_y(c_y), .frame_start(c_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int de_cnt, hs_cnt, vs_cnt, fs_cnt, fs_pos_sum, xmax, ymax, ab_diff, c_hs_cnt, c_de_cnt;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    ticks(3);

    // Reset state and constants
    check_b("rst_a_hs", a_hs, 1'b0);
    check_b("rst_a_vs", a_vs, 1'b0);
    check_b("rst_a_de", a_de, 1'b0);
    check_n("rst_a_x", int'(a_x), 0);
    check_n("rst_a_y", int'(a_y), 0);
    check_b("rst_a_fs", a_fs, 1'b0);
    check_b("rst_b_hs", b_hs, 1'b1);
    check_b("rst_b_vs", b_vs, 1'b1);
    check_n("a_hactive", int'(a_hact), 8);
    check_n("a_vactive", int'(a_vact), 4);
    check_n("c_hactive", int'(c_hact), 1920);
    check_n("c_vactive", int'(c_vact), 1080);
    check_b("rst_c_hs", c_hs, 1'b0);

    // Release reset: the first output reflects position (0,0)
    rst = 1'b0;
    tick();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_pos_sum = 0;
    xmax = 0; ymax = 0; ab_diff = 0; c_hs_cnt = 0; c_de_cnt = 0;

    // Two full small frames (16x8 = 128 cycles each)
    for (int k = 0; k < 256; k++) begin
      if (a_de) de_cnt++;
      if (a_hs) hs_cnt++;
      if (a_vs) vs_cnt++;
      if (a_fs) begin fs_cnt++; fs_pos_sum += k; end
      if (int'(a_x) > xmax) xmax = int'(a_x);
      if (int'(a_y) > ymax) ymax = int'(a_y);
      if ((b_hs !== ~a_hs) || (b_vs !== ~a_vs) || (b_de !== a_de) ||
          (b_x !== a_x) || (b_y !== a_y) || (b_fs !== a_fs)) ab_diff++;
      if (c_hs) c_hs_cnt++;
      if (c_de) c_de_cnt++;
      if (k == 0) begin
        check_b("k0_a_hs", a_hs, 1'b1);
        check_b("k0_a_vs", a_vs, 1'b1);
        check_b("k0_a_fs", a_fs, 1'b1);
        check_b("k0_a_de", a_de, 1'b0);
        check_b("k0_b_hs", b_hs, 1'b0);
        check_b("k0_b_vs", b_vs, 1'b0);
        check_b("k0_b_fs", b_fs, 1'b1);
        check_b("k0_c_hs", c_hs, 1'b1);
        check_b("k0_c_vs", c_vs, 1'b1);
        check_b("k0_c_fs", c_fs, 1'b1);
        check_b("k0_c_de", c_de, 1'b0);
      end
      if (k == 1) begin
        check_b("k1_a_hs", a_hs, 1'b1);
        check_b("k1_a_fs", a_fs, 1'b0);
      end
      if (k == 2)  check_b("k2_a_hs", a_hs, 1'b0);
      if (k == 15) check_b("k15_a_vs", a_vs, 1'b1);
      if (k == 16) begin
        check_b("k16_a_vs", a_vs, 1'b0);
        check_b("k16_a_hs", a_hs, 1'b1);
      end
      if (k == 53) check_b("k53_a_de", a_de, 1'b0);
      if (k == 54) begin
        check_b("k54_a_de", a_de, 1'b1);
        check_n("k54_a_x", int'(a_x), 0);
        check_n("k54_a_y", int'(a_y), 0);
      end
      if (k == 61) check_n("k61_a_x", int'(a_x), 7);
      if (k == 62) begin
        check_b("k62_a_de", a_de, 1'b0);
        check_n("k62_a_x", int'(a_x), 0);
      end
      if (k == 70) begin
        check_n("k70_a_x", int'(a_x), 0);
        check_n("k70_a_y", int'(a_y), 1);
      end
      if (k == 109) begin
        check_b("k109_a_de", a_de, 1'b1);
        check_n("k109_a_x", int'(a_x), 7);
        check_n("k109_a_y", int'(a_y), 3);
      end
      if (k == 110) begin
        check_b("k110_a_de", a_de, 1'b0);
        check_n("k110_a_y", int'(a_y), 0);
      end
      if (k == 118) check_b("k118_a_de", a_de, 1'b0);
      tick();
    end

    check_n("de_count_2fr", de_cnt, 64);
    check_n("hs_count_2fr", hs_cnt, 32);
    check_n("vs_count_2fr", vs_cnt, 32);
    check_n("fs_count_2fr", fs_cnt, 2);
    check_n("fs_pos_sum", fs_pos_sum, 128);
    check_n("x_max", xmax, 7);
    check_n("y_max", ymax, 3);
    check_n("pol_b_vs_a_diff", ab_diff, 0);
    check_n("c_hs_first_line", c_hs_cnt, 44);
    check_n("c_de_first_cycles", c_de_cnt, 0);

    // Third frame start: pause with frame_start asserted
    check_b("k256_a_fs", a_fs, 1'b1);
    en = 1'b0;
    tick();
    check_b("hold_fs_1", a_fs, 1'b1);
    tick();
    check_b("hold_fs_2", a_fs, 1'b1);
    check_b("hold_hs_2", a_hs, 1'b1);
    en = 1'b1;
    tick();
    check_b("resume_fs", a_fs, 1'b0);
    check_b("resume_hs", a_hs, 1'b1);

    // Pause mid-active at x=3 of the first active line
    ticks(56);
    check_b("pre_pause_de", a_de, 1'b1);
    check_n("pre_pause_x", int'(a_x), 3);
    check_n("pre_pause_y", int'(a_y), 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_n("pause_x", int'(a_x), 3);
      check_b("pause_de", a_de, 1'b1);
      check_b("pause_hs", a_hs, 1'b0);
    end
    en = 1'b1;
    tick();
    check_n("resume_x", int'(a_x), 4);
    check_b("resume_de", a_de, 1'b1);

    // Reset on line 5 at x=6, with en low to show reset dominates
    ticks(34);
    check_n("pre_rst_x", int'(a_x), 6);
    check_n("pre_rst_y", int'(a_y), 2);
    check_b("pre_rst_de", a_de, 1'b1);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    check_b("midrst_a_hs", a_hs, 1'b0);
    check_b("midrst_a_vs", a_vs, 1'b0);
    check_b("midrst_a_de", a_de, 1'b0);
    check_n("midrst_a_x", int'(a_x), 0);
    check_n("midrst_a_y", int'(a_y), 0);
    check_b("midrst_a_fs", a_fs, 1'b0);
    check_b("midrst_b_hs", b_hs, 1'b1);
    check_b("midrst_b_vs", b_vs, 1'b1);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    check_b("restart_fs", a_fs, 1'b1);
    check_b("restart_hs", a_hs, 1'b1);
    check_b("restart_vs", a_vs, 1'b1);
    check_b("restart_de", a_de, 1'b0);
    tick();
    check_b("restart_k1_fs", a_fs, 1'b0);
    check_b("restart_k1_hs", a_hs, 1'b1);
    tick();
    check_b("restart_k2_hs", a_hs, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
